hog_cell_scan_counter: RTL and testbench
========================================

Name: hog_cell_scan_counter

Overview:
Parametrised raster-scan position tracker for the HOG pipeline, succeeding the single-axis cell counter. It accepts one pixel per enabled cycle and tags each pixel with x/y, cell column/row and linear cell index. It also emits registered last-in-cell, block-ready and frame-done events that the histogram and normalisation stages consume. It supports a free-running wrap mode and a one-shot mode that halts at frame end.

Parameters:
IMG_W, 64, pixels per image row; must be a multiple of CELL_SIZE.
IMG_H, 128, pixel rows per frame; must be a multiple of CELL_SIZE.
CELL_SIZE, 8, cell edge in pixels, power of two, >=2.
BLOCK_CELLS, 2, block edge in cells; block stride is 1 cell.
WRAP_MODE, 1, 1 = restart at (0,0) after the last pixel; 0 = halt with oDone until iStart.

Ports:
iClk  in  1  clock; all logic on rising edge.
iRst  in  1  reset, synchronous, active-high.
iEn  in  1  pixel strobe; one pixel is accepted per cycle when high and not halted.
iStart  in  1  synchronous frame restart; clears position to (0,0) and clears oDone.
oValid  out  1  registered; high the cycle after a pixel is accepted.
oPixX  out  clog2(IMG_W)  x of the accepted pixel.
oPixY  out  clog2(IMG_H)  y of the accepted pixel.
oCellCol  out  clog2(IMG_W/CELL_SIZE)  cell column of the accepted pixel.
oCellRow  out  clog2(IMG_H/CELL_SIZE)  cell row of the accepted pixel.
oCellIdx  out  clog2(NCX*NCY)  oCellRow*NCX + oCellCol, where NCX = IMG_W/CELL_SIZE and NCY = IMG_H/CELL_SIZE.
oLastInCell  out  1  accepted pixel is the bottom-right pixel of its cell.
oBlockReady  out  1  accepted pixel completes a block.
oBlockCol  out  width of oCellCol  oCellCol-(BLOCK_CELLS-1); valid only with oBlockReady.
oBlockRow  out  width of oCellRow  oCellRow-(BLOCK_CELLS-1); valid only with oBlockReady.
oFrameDone  out  1  accepted pixel is (IMG_W-1, IMG_H-1).
oDone  out  1  level; halted state, WRAP_MODE=0 only.

Behaviour:
- Reset: iRst has priority over all other inputs, regardless of iEn (unlike the previous cell counter). All outputs and internal counters go to 0.
- Internal next-position state: px (0..CELL_SIZE-1), cx (0..NCX-1), py (0..CELL_SIZE-1), cy (0..NCY-1).
  - x = cx*CELL_SIZE + px; y = cy*CELL_SIZE + py.
  - Multiplies by the power-of-two CELL_SIZE are bit concatenation. oCellIdx uses a constant multiply.
- Accept condition: acc = iEn & ~halted.
- When acc is high:
  - Output registers load the current position plus the flags; oValid is set to 1.
  - px increments; on px wrap, cx increments.
  - On cx wrap, py increments; on py wrap, cy increments; on cy wrap, the position becomes (0,0).
- When acc is low, oValid = 0, all event flags = 0, and the coordinate outputs hold their last values.
- Latency: exactly 1 cycle from accept to tagged outputs. Back-to-back iEn gives one pixel per cycle with no bubbles.
- Event flags (all gated by oValid):
  - oLastInCell = (px==CELL_SIZE-1)&(py==CELL_SIZE-1).
  - oBlockReady = oLastInCell & (cx>=BLOCK_CELLS-1) & (cy>=BLOCK_CELLS-1).
  - oFrameDone = oLastInCell & (cx==NCX-1) & (cy==NCY-1).
- Frame end, WRAP_MODE=1: position returns to (0,0) and oDone stays 0.
- Frame end, WRAP_MODE=0: halted is set and oDone=1 from the cycle oFrameDone is high. iEn is ignored while halted.
- iStart without iRst: position clears to (0,0) and halted clears.
  - If iEn is also high in the same cycle, that pixel is accepted as (0,0); the counters then hold the successor (1,0).
  - A frame aborted mid-way emits no oFrameDone.
- Elaboration: $error if IMG_W%CELL_SIZE != 0, IMG_H%CELL_SIZE != 0, CELL_SIZE is not a power of two, or BLOCK_CELLS > min(NCX,NCY).

Decomposition:
- Package hog_scan_pkg: default geometry constants, derived widths and NCX/NCY helper functions, a scan_pos_t struct (x, y, cell_col, cell_row).
- One sub-module, hog_wrap_counter:
  - Parameter: MAX.
  - Inputs: iClk, iRst, iClr, iInc.
  - Outputs: count and terminal (count==MAX).
  - Instantiated four times and chained through terminal&inc.

Test Plan:
- Reset mid-frame: 300 pixels, iRst with iEn=1 -> next cycle oValid=0 and all outputs 0; the next pixel is tagged (0,0), cell 0.
- Full frame with defaults, continuous iEn -> 8192 oValid, 128 oLastInCell, 105 oBlockReady, 1 oFrameDone on pixel (63,127). First oBlockReady is on pixel (15,15) with block (0,0); cell idx 127 appears last.
- Wrap mode: 2 consecutive frames -> the pixel after (63,127) is tagged (0,0) with no gap; oDone stays 0.
- One-shot WRAP_MODE=0: oDone=1 after pixel 8191 and further iEn gives oValid=0. iStart+iEn in the same cycle -> pixel tagged (0,0), next pixel (1,0), oDone=0.
- Gapped iEn, random 50% duty -> coordinates are identical to the continuous run pixel-for-pixel and flags never assert while oValid=0.
- Small config IMG_W=16, IMG_H=8, CELL_SIZE=4, BLOCK_CELLS=2 -> 8 oLastInCell and 3 oBlockReady at pixels (7,7), (11,7) and (15,7) with blocks (0,0), (1,0) and (2,0).

Source files
------------

// File: rtl/hog_scan_pkg.sv
// Shared geometry defaults, width helpers and the scan position record
// used by the HOG raster-scan position tracker.
package hog_scan_pkg;

    localparam int DEF_IMG_W       = 64;
    localparam int DEF_IMG_H       = 128;
    localparam int DEF_CELL_SIZE   = 8;
    localparam int DEF_BLOCK_CELLS = 2;
    localparam int DEF_WRAP_MODE   = 1;

    // Bits needed to hold values 0..n-1, never less than one bit.
    function automatic int wbits(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Number of cell columns across an image row.
    function automatic int ncx(input int img_w, input int cell_size);
        return img_w / cell_size;
    endfunction

    // Number of cell rows down a frame.
    function automatic int ncy(input int img_h, input int cell_size);
        return img_h / cell_size;
    endfunction

    // Geometry-independent container for one tagged pixel position.
    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] cell_col;
        logic [15:0] cell_row;
    } scan_pos_t;

endpackage

// File: rtl/hog_wrap_counter.sv
// Modulo-(MAX+1) counter with synchronous clear and a terminal flag.
// Clear and increment together load 1, so a restart cycle that also
// consumes a pixel leaves the counter holding the successor position.
module hog_wrap_counter
    import hog_scan_pkg::*;
#(
    parameter int MAX = 7
) (
    input  logic                      iClk,
    input  logic                      iRst,
    input  logic                      iClr,
    input  logic                      iInc,
    output logic [wbits(MAX+1)-1:0]   count,
    output logic                      terminal
);

    localparam int W = wbits(MAX + 1);
    localparam logic [W-1:0] MAX_V = W'(MAX);

    assign terminal = (count == MAX_V);

    // Count register: reset, then restart, then wrap-around increment.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            count <= '0;
        end else if (iClr) begin
            count <= (iInc && (MAX != 0)) ? W'(1) : '0;
        end else if (iInc) begin
            count <= terminal ? '0 : count + W'(1);
        end
    end

endmodule

// File: rtl/hog_cell_scan_counter.sv
// Raster-scan position tracker for the HOG pipeline. Tags each accepted
// pixel with x/y, cell column/row, linear cell index and registered
// last-in-cell / block-ready / frame-done events, one cycle after accept.
module hog_cell_scan_counter
    import hog_scan_pkg::*;
#(
    parameter int IMG_W       = DEF_IMG_W,
    parameter int IMG_H       = DEF_IMG_H,
    parameter int CELL_SIZE   = DEF_CELL_SIZE,
    parameter int BLOCK_CELLS = DEF_BLOCK_CELLS,
    parameter int WRAP_MODE   = DEF_WRAP_MODE
) (
    input  logic                                        iClk,
    input  logic                                        iRst,
    input  logic                                        iEn,
    input  logic                                        iStart,
    output logic                                        oValid,
    output logic [wbits(IMG_W)-1:0]                     oPixX,
    output logic [wbits(IMG_H)-1:0]                     oPixY,
    output logic [wbits(ncx(IMG_W, CELL_SIZE))-1:0]     oCellCol,
    output logic [wbits(ncy(IMG_H, CELL_SIZE))-1:0]     oCellRow,
    output logic [wbits(ncx(IMG_W, CELL_SIZE) *
                        ncy(IMG_H, CELL_SIZE))-1:0]     oCellIdx,
    output logic                                        oLastInCell,
    output logic                                        oBlockReady,
    output logic [wbits(ncx(IMG_W, CELL_SIZE))-1:0]     oBlockCol,
    output logic [wbits(ncy(IMG_H, CELL_SIZE))-1:0]     oBlockRow,
    output logic                                        oFrameDone,
    output logic                                        oDone
);

    localparam int NCX = ncx(IMG_W, CELL_SIZE);
    localparam int NCY = ncy(IMG_H, CELL_SIZE);
    localparam int XW  = wbits(IMG_W);
    localparam int YW  = wbits(IMG_H);
    localparam int PW  = wbits(CELL_SIZE);
    localparam int CW  = wbits(NCX);
    localparam int RW  = wbits(NCY);
    localparam int IW  = wbits(NCX * NCY);
    localparam bit ONE_SHOT = (WRAP_MODE == 0);
    localparam logic [CW-1:0] BLK_OFS_C = CW'(BLOCK_CELLS - 1);
    localparam logic [RW-1:0] BLK_OFS_R = RW'(BLOCK_CELLS - 1);

    // Reject geometries the concatenation-based addressing cannot handle.
    if ((IMG_W % CELL_SIZE) != 0) begin : g_bad_w
        $error("IMG_W must be a multiple of CELL_SIZE");
    end
    if ((IMG_H % CELL_SIZE) != 0) begin : g_bad_h
        $error("IMG_H must be a multiple of CELL_SIZE");
    end
    if ((CELL_SIZE < 2) || ((CELL_SIZE & (CELL_SIZE - 1)) != 0)) begin : g_bad_cell
        $error("CELL_SIZE must be a power of two and at least 2");
    end
    if ((BLOCK_CELLS > NCX) || (BLOCK_CELLS > NCY)) begin : g_bad_block
        $error("BLOCK_CELLS exceeds the cell grid");
    end

    logic          halted;
    logic          acc;
    logic [PW-1:0] px_cnt, py_cnt, cur_px, cur_py;
    logic [CW-1:0] cx_cnt, cur_cx;
    logic [RW-1:0] cy_cnt, cur_cy;
    logic          px_t, cx_t, py_t, cy_t;
    logic          px_te, cx_te, py_te, cy_te;
    logic          cx_inc, py_inc, cy_inc;
    logic          last_c, block_c, frame_c;

    // A restart reopens acceptance even while halted.
    assign acc = iEn & (~halted | iStart);

    // Counter chain: each stage advances when all faster stages wrap.
    // On a restart the visible position is (0,0), so no stage is terminal.
    assign px_te  = px_t & ~iStart;
    assign cx_te  = cx_t & ~iStart;
    assign py_te  = py_t & ~iStart;
    assign cy_te  = cy_t & ~iStart;
    assign cx_inc = acc & px_te;
    assign py_inc = cx_inc & cx_te;
    assign cy_inc = py_inc & py_te;

    hog_wrap_counter #(.MAX(CELL_SIZE - 1)) u_px (
        .iClk(iClk), .iRst(iRst), .iClr(iStart), .iInc(acc),
        .count(px_cnt), .terminal(px_t)
    );
    hog_wrap_counter #(.MAX(NCX - 1)) u_cx (
        .iClk(iClk), .iRst(iRst), .iClr(iStart), .iInc(cx_inc),
        .count(cx_cnt), .terminal(cx_t)
    );
    hog_wrap_counter #(.MAX(CELL_SIZE - 1)) u_py (
        .iClk(iClk), .iRst(iRst), .iClr(iStart), .iInc(py_inc),
        .count(py_cnt), .terminal(py_t)
    );
    hog_wrap_counter #(.MAX(NCY - 1)) u_cy (
        .iClk(iClk), .iRst(iRst), .iClr(iStart), .iInc(cy_inc),
        .count(cy_cnt), .terminal(cy_t)
    );

    // Position of the pixel being accepted this cycle and its event flags.
    always_comb begin
        cur_px  = iStart ? '0 : px_cnt;
        cur_cx  = iStart ? '0 : cx_cnt;
        cur_py  = iStart ? '0 : py_cnt;
        cur_cy  = iStart ? '0 : cy_cnt;
        last_c  = px_te & py_te;
        block_c = last_c & (cur_cx >= BLK_OFS_C) & (cur_cy >= BLK_OFS_R);
        frame_c = last_c & cx_te & cy_te;
    end

    // Output tagging register: coordinates hold when nothing is accepted.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            oValid      <= 1'b0;
            oPixX       <= '0;
            oPixY       <= '0;
            oCellCol    <= '0;
            oCellRow    <= '0;
            oCellIdx    <= '0;
            oLastInCell <= 1'b0;
            oBlockReady <= 1'b0;
            oBlockCol   <= '0;
            oBlockRow   <= '0;
            oFrameDone  <= 1'b0;
        end else begin
            oValid      <= acc;
            oLastInCell <= acc & last_c;
            oBlockReady <= acc & block_c;
            oFrameDone  <= acc & frame_c;
            if (acc) begin
                oPixX     <= XW'({cur_cx, cur_px});
                oPixY     <= YW'({cur_cy, cur_py});
                oCellCol  <= cur_cx;
                oCellRow  <= cur_cy;
                oCellIdx  <= IW'(cur_cy) * IW'(NCX) + IW'(cur_cx);
                oBlockCol <= cur_cx - BLK_OFS_C;
                oBlockRow <= cur_cy - BLK_OFS_R;
            end
        end
    end

    // Halt flag: one-shot mode stops at frame end until the next restart.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            halted <= 1'b0;
        end else begin
            halted <= (halted & ~iStart) | (ONE_SHOT & acc & frame_c);
        end
    end

    assign oDone = halted;

endmodule

// File: tb/tb_hog_cell_scan_counter.sv
// Bench for hog_cell_scan_counter: three instances (default wrap, default
// one-shot, small 16x8 geometry) driven one at a time from a single driver.
// Expected tags come from a linear-pixel-index model; a negedge monitor
// pops and compares whenever an instance presents oValid.
module tb_hog_cell_scan_counter;
    import hog_scan_pkg::*;

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] col;
        logic [15:0] row;
        logic [15:0] idx;
        logic        last;
        logic        blk;
        logic [15:0] bcol;
        logic [15:0] brow;
        logic        fd;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] en_s = '0;
    logic [2:0] st_s = '0;
    logic [2:0] rs_s = '0;

    // Instance outputs
    logic       a_v, a_last, a_blk, a_fd, a_done;
    logic [5:0] a_x;  logic [6:0] a_y;  logic [2:0] a_col, a_bcol;
    logic [3:0] a_row, a_brow;          logic [6:0] a_idx;
    logic       b_v, b_last, b_blk, b_fd, b_done;
    logic [5:0] b_x;  logic [6:0] b_y;  logic [2:0] b_col, b_bcol;
    logic [3:0] b_row, b_brow;          logic [6:0] b_idx;
    logic       c_v, c_last, c_blk, c_fd, c_done;
    logic [3:0] c_x;  logic [2:0] c_y;  logic [1:0] c_col, c_bcol;
    logic [0:0] c_row, c_brow;          logic [2:0] c_idx;

    hog_cell_scan_counter #(.IMG_W(64), .IMG_H(128), .CELL_SIZE(8), .BLOCK_CELLS(2), .WRAP_MODE(1)) dut_a (
        .iClk(clk), .iRst(rs_s[0]), .iEn(en_s[0]), .iStart(st_s[0]), .oValid(a_v),
        .oPixX(a_x), .oPixY(a_y), .oCellCol(a_col), .oCellRow(a_row), .oCellIdx(a_idx),
        .oLastInCell(a_last), .oBlockReady(a_blk), .oBlockCol(a_bcol), .oBlockRow(a_brow),
        .oFrameDone(a_fd), .oDone(a_done)
    );
    hog_cell_scan_counter #(.IMG_W(64), .IMG_H(128), .CELL_SIZE(8), .BLOCK_CELLS(2), .WRAP_MODE(0)) dut_b (
        .iClk(clk), .iRst(rs_s[1]), .iEn(en_s[1]), .iStart(st_s[1]), .oValid(b_v),
        .oPixX(b_x), .oPixY(b_y), .oCellCol(b_col), .oCellRow(b_row), .oCellIdx(b_idx),
        .oLastInCell(b_last), .oBlockReady(b_blk), .oBlockCol(b_bcol), .oBlockRow(b_brow),
        .oFrameDone(b_fd), .oDone(b_done)
    );
    hog_cell_scan_counter #(.IMG_W(16), .IMG_H(8), .CELL_SIZE(4), .BLOCK_CELLS(2), .WRAP_MODE(1)) dut_c (
        .iClk(clk), .iRst(rs_s[2]), .iEn(en_s[2]), .iStart(st_s[2]), .oValid(c_v),
        .oPixX(c_x), .oPixY(c_y), .oCellCol(c_col), .oCellRow(c_row), .oCellIdx(c_idx),
        .oLastInCell(c_last), .oBlockReady(c_blk), .oBlockCol(c_bcol), .oBlockRow(c_brow),
        .oFrameDone(c_fd), .oDone(c_done)
    );

    // Actual tags in the same zero-extended record as the model
    exp_t act [3];
    logic vld [3];
    logic dn  [3];
    assign act[0] = '{x: 16'(a_x), y: 16'(a_y), col: 16'(a_col), row: 16'(a_row), idx: 16'(a_idx),
                      last: a_last, blk: a_blk, bcol: a_blk ? 16'(a_bcol) : 16'd0,
                      brow: a_blk ? 16'(a_brow) : 16'd0, fd: a_fd};
    assign act[1] = '{x: 16'(b_x), y: 16'(b_y), col: 16'(b_col), row: 16'(b_row), idx: 16'(b_idx),
                      last: b_last, blk: b_blk, bcol: b_blk ? 16'(b_bcol) : 16'd0,
                      brow: b_blk ? 16'(b_brow) : 16'd0, fd: b_fd};
    assign act[2] = '{x: 16'(c_x), y: 16'(c_y), col: 16'(c_col), row: 16'(c_row), idx: 16'(c_idx),
                      last: c_last, blk: c_blk, bcol: c_blk ? 16'(c_bcol) : 16'd0,
                      brow: c_blk ? 16'(c_brow) : 16'd0, fd: c_fd};
    assign vld[0] = a_v;  assign vld[1] = b_v;  assign vld[2] = c_v;
    assign dn[0]  = a_done; assign dn[1] = b_done; assign dn[2] = c_done;

    // Reference model state
    int geo_w [3] = '{64, 64, 16};
    int geo_h [3] = '{128, 128, 8};
    int geo_c [3] = '{8, 8, 4};
    int geo_b [3] = '{2, 2, 2};
    bit geo_wrap [3] = '{1'b1, 1'b0, 1'b1};
    int  mdl_n [3] = '{0, 0, 0};
    bit  mdl_halt [3] = '{1'b0, 1'b0, 1'b0};

    exp_t exp_q0[$];
    exp_t exp_q1[$];
    exp_t exp_q2[$];

    int checks = 0;
    int errors = 0;

    // Event tallies kept by the monitor only
    int cnt_last [3] = '{0, 0, 0};
    int cnt_blk  [3] = '{0, 0, 0};
    int cnt_fd   [3] = '{0, 0, 0};
    int fd_x     [3] = '{0, 0, 0};
    int fd_y     [3] = '{0, 0, 0};

    // Tags of linear pixel n in a W x H raster with CxC cells, BxB blocks
    function automatic exp_t tag_of(input int n, input int w, input int h, input int c, input int b);
        exp_t e;
        int x, y, col, row;
        x = n % w;
        y = n / w;
        col = x / c;
        row = y / c;
        e.x = 16'(x);
        e.y = 16'(y);
        e.col = 16'(col);
        e.row = 16'(row);
        e.idx = 16'(row * (w / c) + col);
        e.last = ((x % c) == c - 1) && ((y % c) == c - 1);
        e.blk = e.last && (col >= b - 1) && (row >= b - 1);
        e.bcol = e.blk ? 16'(col - (b - 1)) : 16'd0;
        e.brow = e.blk ? 16'(row - (b - 1)) : 16'd0;
        e.fd = (x == w - 1) && (y == h - 1);
        return e;
    endfunction

    function automatic void push_exp(input int k, input exp_t e);
        case (k)
            0: exp_q0.push_back(e);
            1: exp_q1.push_back(e);
            default: exp_q2.push_back(e);
        endcase
    endfunction

    function automatic bit pop_exp(input int k, output exp_t e);
        e = '0;
        case (k)
            0: begin if (exp_q0.size() == 0) return 1'b0; e = exp_q0.pop_front(); end
            1: begin if (exp_q1.size() == 0) return 1'b0; e = exp_q1.pop_front(); end
            default: begin if (exp_q2.size() == 0) return 1'b0; e = exp_q2.pop_front(); end
        endcase
        return 1'b1;
    endfunction

    function automatic void chk(input string name, input logic [127:0] got, input logic [127:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endfunction

    // Driver: present one cycle of inputs to instance k and advance its model
    task automatic drive(input int k, input bit en, input bit st, input bit rs);
        @(posedge clk);
        #1;
        en_s = '0;
        st_s = '0;
        rs_s = '0;
        en_s[k] = en;
        st_s[k] = st;
        rs_s[k] = rs;
        if (rs) begin
            mdl_n[k] = 0;
            mdl_halt[k] = 1'b0;
        end else begin
            if (st) begin
                mdl_n[k] = 0;
                mdl_halt[k] = 1'b0;
            end
            if (en && !mdl_halt[k]) begin
                exp_t e;
                e = tag_of(mdl_n[k], geo_w[k], geo_h[k], geo_c[k], geo_b[k]);
                push_exp(k, e);
                if (e.fd && !geo_wrap[k]) mdl_halt[k] = 1'b1;
                mdl_n[k] = (mdl_n[k] + 1) % (geo_w[k] * geo_h[k]);
            end
        end
    endtask

    task automatic run(input int k, input int cycles, input bit gapped);
        for (int i = 0; i < cycles; i++) begin
            drive(k, gapped ? ($urandom_range(0, 1) == 1) : 1'b1, 1'b0, 1'b0);
        end
    endtask

    // Monitor: compare every presented pixel with the head of its queue
    initial begin
        forever begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                if (vld[k]) begin
                    exp_t e;
                    checks++;
                    if (!pop_exp(k, e)) begin
                        errors++;
                        $display("FAIL unexpected_valid inst%0d: got tag %h with no pixel expected", k, act[k]);
                    end else if (act[k] !== e) begin
                        errors++;
                        $display("FAIL pixel_tag inst%0d: got %h expected %h", k, act[k], e);
                    end
                    cnt_last[k] += int'(act[k].last);
                    cnt_blk[k]  += int'(act[k].blk);
                    if (act[k].fd) begin
                        cnt_fd[k]++;
                        fd_x[k] = int'(act[k].x);
                        fd_y[k] = int'(act[k].y);
                    end
                end else begin
                    chk($sformatf("flags_idle inst%0d", k),
                        128'({act[k].last, act[k].blk, act[k].fd}), 128'd0);
                end
                if (geo_wrap[k]) chk($sformatf("done_low_wrap inst%0d", k), 128'(dn[k]), 128'd0);
            end
        end
    end

    int s_last, s_blk, s_fd;

    initial begin
        // Clock/reset block
        rs_s = 3'b111;
        repeat (2) @(posedge clk);
        #1;
        rs_s = 3'b000;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("reset_state inst%0d", k), 128'({vld[k], dn[k], act[k]}), 128'd0);
        end

        // Reset mid-frame with iEn high
        run(0, 300, 1'b0);
        drive(0, 1'b1, 1'b0, 1'b1);
        drive(0, 1'b0, 1'b0, 1'b0);
        chk("reset_midframe", 128'({vld[0], dn[0], act[0]}), 128'd0);

        // Two continuous default frames in wrap mode
        s_last = cnt_last[0]; s_blk = cnt_blk[0]; s_fd = cnt_fd[0];
        run(0, 8192, 1'b0);
        drive(0, 1'b0, 1'b0, 1'b0);
        drive(0, 1'b0, 1'b0, 1'b0);
        chk("frame1_last_count", 128'(cnt_last[0] - s_last), 128'd128);
        chk("frame1_block_count", 128'(cnt_blk[0] - s_blk), 128'd105);
        chk("frame1_done_count", 128'(cnt_fd[0] - s_fd), 128'd1);
        chk("frame1_done_pixel", 128'({fd_x[0], fd_y[0]}), 128'({32'd63, 32'd127}));
        run(0, 8192 + 40, 1'b0);
        chk("wrap_done_level", 128'(dn[0]), 128'd0);

        // Gapped strobe, 50% duty
        run(0, 4000, 1'b1);

        // One-shot mode
        run(1, 8192, 1'b0);
        drive(1, 1'b0, 1'b0, 1'b0);
        chk("oneshot_done_set", 128'(dn[1]), 128'd1);
        run(1, 5, 1'b0);
        drive(1, 1'b0, 1'b0, 1'b0);
        chk("oneshot_done_held", 128'(dn[1]), 128'd1);
        drive(1, 1'b1, 1'b1, 1'b0);
        drive(1, 1'b1, 1'b0, 1'b0);
        drive(1, 1'b0, 1'b0, 1'b0);
        chk("restart_done_clear", 128'(dn[1]), 128'd0);
        run(1, 100, 1'b0);
        drive(1, 1'b0, 1'b1, 1'b0);
        s_fd = cnt_fd[1];
        run(1, 8192, 1'b0);
        drive(1, 1'b0, 1'b0, 1'b0);
        drive(1, 1'b0, 1'b0, 1'b0);
        chk("abort_frame_done_count", 128'(cnt_fd[1] - s_fd), 128'd1);
        chk("abort_done_set", 128'(dn[1]), 128'd1);

        // Small geometry 16x8, 4x4 cells
        s_last = cnt_last[2]; s_blk = cnt_blk[2]; s_fd = cnt_fd[2];
        run(2, 128, 1'b0);
        drive(2, 1'b0, 1'b0, 1'b0);
        drive(2, 1'b0, 1'b0, 1'b0);
        chk("small_last_count", 128'(cnt_last[2] - s_last), 128'd8);
        chk("small_block_count", 128'(cnt_blk[2] - s_blk), 128'd3);
        chk("small_done_pixel", 128'({fd_x[2], fd_y[2]}), 128'({32'd15, 32'd7}));
        run(2, 300, 1'b1);

        // Drain and confirm every expected pixel appeared
        repeat (3) drive(0, 1'b0, 1'b0, 1'b0);
        chk("queue0_empty", 128'(exp_q0.size()), 128'd0);
        chk("queue1_empty", 128'(exp_q1.size()), 128'd0);
        chk("queue2_empty", 128'(exp_q2.size()), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
